// File: rtl/serial_operand_feeder_if.sv
// Operand handshake and serial adder-side signals for serial_operand_feeder.
// master: upstream producer (drives operands, observes the serial stream).
// slave:  the feeder itself.
interface serial_operand_feeder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             a;
    logic             b;
    logic             adder_rst;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, op_a, op_b,
        input  in_ready, a, b, adder_rst, busy, done
    );

    modport slave (
        input  in_valid, op_a, op_b,
        output in_ready, a, b, adder_rst, busy, done
    );
endinterface

// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: captures a WIDTH-bit operand pair on a valid/ready
// handshake and streams it LSB-first onto the serial adder's a/b inputs,
// optionally followed by one zero bit so the adder can emit its carry-out.
// adder_rst is held high whenever no frame is streaming.
// Every output is a register or a pure decode of the state register, so
// nothing on the input side can reach the outputs combinationally.
module serial_operand_feeder #(
    parameter int WIDTH  = 8,
    parameter bit EXTEND = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_operand_feeder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sa, sa_d;
    logic [WIDTH-1:0] sb, sb_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             done_q, done_d;

    // State, shift registers, bit counter and done pulse; reset drops any
    // partial frame without producing a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            sa     <= sa_d;
            sb     <= sb_d;
            cnt    <= cnt_d;
            done_q <= done_d;
        end
    end

    // Next-state logic: load on handshake, shift one bit per cycle, then
    // optionally one zero cycle; done is raised for the first IDLE cycle.
    always_comb begin
        state_d = state;
        sa_d    = sa;
        sb_d    = sb;
        cnt_d   = cnt;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sa_d    = bus.op_a;
                    sb_d    = bus.op_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Zero fill keeps a/b quiet in FLUSH and after the frame.
                sa_d  = sa >> 1;
                sb_d  = sb >> 1;
                cnt_d = cnt + CW'(1);
                if (cnt == LAST) begin
                    if (EXTEND) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state and registered data only.
    assign bus.in_ready  = (state == IDLE);
    assign bus.adder_rst = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.a         = (state == SHIFT) & sa[0];
    assign bus.b         = (state == SHIFT) & sb[0];
    assign bus.done      = done_q;
endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder. Three instances share clock and reset:
// u0 WIDTH=8 EXTEND=1, u1 WIDTH=8 EXTEND=0, u2 WIDTH=1 EXTEND=1.
// A stream model (queue of expected per-cycle outputs built from the frame
// timing rules) checks every instance every cycle; a vector table and
// hand-written sequences add explicit checks of the documented cases.
module tb_serial_operand_feeder;
    typedef struct packed {
        logic a;
        logic b;
        logic adder_rst;
        logic in_ready;
        logic busy;
        logic done;
    } obs_t;

    localparam obs_t IDLE_O = 6'b001100;
    localparam obs_t DONE_O = 6'b001101;
    localparam obs_t ZERO_O = 6'b000010;

    typedef struct {
        int         d;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [8:0] ea;
        logic [8:0] eb;
        int         len;
    } vec_t;

    logic clk;
    logic rst;

    serial_operand_feeder_if #(.WIDTH(8)) i0 ();
    serial_operand_feeder_if #(.WIDTH(8)) i1 ();
    serial_operand_feeder_if #(.WIDTH(1)) i2 ();

    serial_operand_feeder #(.WIDTH(8), .EXTEND(1'b1)) u0 (.clk(clk), .rst(rst), .bus(i0));
    serial_operand_feeder #(.WIDTH(8), .EXTEND(1'b0)) u1 (.clk(clk), .rst(rst), .bus(i1));
    serial_operand_feeder #(.WIDTH(1), .EXTEND(1'b1)) u2 (.clk(clk), .rst(rst), .bus(i2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_fail;
    int         W[3];
    int         E[3];
    obs_t       exp_q[3][$];
    obs_t       cur[3];
    logic       drv_v[3];
    logic [7:0] drv_a[3];
    logic [7:0] drv_b[3];

    function automatic obs_t get_obs(int d);
        obs_t o;
        case (d)
            0:       o = {i0.a, i0.b, i0.adder_rst, i0.in_ready, i0.busy, i0.done};
            1:       o = {i1.a, i1.b, i1.adder_rst, i1.in_ready, i1.busy, i1.done};
            default: o = {i2.a, i2.b, i2.adder_rst, i2.in_ready, i2.busy, i2.done};
        endcase
        return o;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_obs(string name, int d, obs_t act, obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got {a,b,arst,rdy,busy,done}=%b expected %b at %0t",
                     name, d, act, exp, $time);
        end
    endtask

    // Expected outputs for one accepted frame, cycle by cycle.
    task automatic push_frame(int d, logic [7:0] oa, logic [7:0] ob);
        for (int k = 0; k < W[d]; k++) exp_q[d].push_back({oa[k], ob[k], 4'b0010});
        if (E[d] != 0) exp_q[d].push_back(ZERO_O);
        exp_q[d].push_back(DONE_O);
    endtask

    task automatic apply_drive();
        i0.in_valid = drv_v[0]; i0.op_a = drv_a[0];      i0.op_b = drv_b[0];
        i1.in_valid = drv_v[1]; i1.op_a = drv_a[1];      i1.op_b = drv_b[1];
        i2.in_valid = drv_v[2]; i2.op_a = drv_a[2][0:0]; i2.op_b = drv_b[2][0:0];
    endtask

    // One clock: drive, let the edge happen, then compare all instances.
    task automatic cycle();
        logic acc[3];
        apply_drive();
        for (int d = 0; d < 3; d++) acc[d] = rst && drv_v[d] && cur[d].in_ready;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (acc[d]) push_frame(d, drv_a[d], drv_b[d]);
            cur[d] = (exp_q[d].size() != 0) ? exp_q[d].pop_front() : IDLE_O;
            check_obs("model", d, get_obs(d), cur[d]);
        end
    endtask

    // Reset asserted between edges: outputs must go idle without a clock.
    task automatic do_async_reset();
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            cur[d] = IDLE_O;
            check_obs("async_rst", d, get_obs(d), cur[d]);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) check_obs("rst_hold", d, get_obs(d), IDLE_O);
        end
        rst = 1'b1;
    endtask

    initial begin
        vec_t vecs[4];
        obs_t o;
        int   s1, s2, gap;
        logic prev;

        n_cmp  = 0;
        n_fail = 0;
        W = '{8, 8, 1};
        E = '{1, 0, 1};
        for (int d = 0; d < 3; d++) begin
            drv_v[d] = 1'b0; drv_a[d] = 8'h00; drv_b[d] = 8'h00; cur[d] = IDLE_O;
        end
        apply_drive();

        // Expected serial streams, LSB first, written from the documented sequences.
        vecs[0] = '{d: 0, opa: 8'hA5, opb: 8'h3C, ea: 9'b0_1010_0101, eb: 9'b0_0011_1100, len: 9};
        vecs[1] = '{d: 1, opa: 8'h81, opb: 8'h00, ea: 9'b0_1000_0001, eb: 9'b0_0000_0000, len: 8};
        vecs[2] = '{d: 2, opa: 8'h01, opb: 8'h01, ea: 9'b0_0000_0001, eb: 9'b0_0000_0001, len: 2};
        vecs[3] = '{d: 2, opa: 8'h01, opb: 8'h00, ea: 9'b0_0000_0001, eb: 9'b0_0000_0000, len: 2};

        // Reset for two cycles.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check_obs("reset", d, get_obs(d), IDLE_O);
        rst = 1'b1;
        repeat (5) cycle();

        // Table-driven single frames.
        for (int v = 0; v < 4; v++) begin
            int d;
            d = vecs[v].d;
            drv_v[d] = 1'b1; drv_a[d] = vecs[v].opa; drv_b[d] = vecs[v].opb;
            cycle();
            drv_v[d] = 1'b0;
            for (int k = 0; k < vecs[v].len; k++) begin
                if (k != 0) cycle();
                o = get_obs(d);
                chk($sformatf("vec%0d_a%0d", v, k), 32'(o.a), 32'(vecs[v].ea[k]));
                chk($sformatf("vec%0d_b%0d", v, k), 32'(o.b), 32'(vecs[v].eb[k]));
                chk($sformatf("vec%0d_arst%0d", v, k), 32'(o.adder_rst), 32'd0);
            end
            cycle();
            o = get_obs(d);
            chk($sformatf("vec%0d_done", v), 32'(o.done), 32'd1);
            chk($sformatf("vec%0d_arst_end", v), 32'(o.adder_rst), 32'd1);
            cycle();
            o = get_obs(d);
            chk($sformatf("vec%0d_done_once", v), 32'(o.done), 32'd0);
            repeat (2) cycle();
        end

        // Back-to-back frames with in_valid held high on u0.
        s1 = -1; s2 = -1; gap = 0; prev = 1'b1;
        drv_v[0] = 1'b1; drv_a[0] = 8'hFF; drv_b[0] = 8'h01;
        for (int t = 0; t < 40; t++) begin
            cycle();
            if (t == 0) begin
                drv_a[0] = 8'h00; drv_b[0] = 8'h80;
            end
            o = get_obs(0);
            if (prev && !o.adder_rst) begin
                if (s1 < 0) s1 = t;
                else if (s2 < 0) begin
                    s2 = t;
                    drv_v[0] = 1'b0;
                end
            end
            if (s1 >= 0 && s2 < 0 && o.adder_rst) gap++;
            prev = o.adder_rst;
        end
        chk("b2b_spacing", 32'(s2 - s1), 32'd10);
        chk("b2b_gap", 32'(gap), 32'd1);

        // Reset in the 4th SHIFT cycle of a u0 frame, then a clean frame.
        drv_v[0] = 1'b1; drv_a[0] = 8'h5A; drv_b[0] = 8'hC3;
        cycle();
        drv_v[0] = 1'b0;
        repeat (3) cycle();
        do_async_reset();
        cycle();
        o = get_obs(0);
        chk("rst_no_done", 32'(o.done), 32'd0);
        drv_v[0] = 1'b1; drv_a[0] = 8'h96; drv_b[0] = 8'h69;
        cycle();
        drv_v[0] = 1'b0;
        o = get_obs(0);
        chk("post_rst_bit0_a", 32'(o.a), 32'd0);
        chk("post_rst_bit0_b", 32'(o.b), 32'd1);
        repeat (10) cycle();

        // in_valid toggling with changing operands while u1 shifts.
        drv_v[1] = 1'b1; drv_a[1] = 8'h3C; drv_b[1] = 8'hA5;
        cycle();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] cap_a, cap_b;
            cap_a = 8'h3C;
            cap_b = 8'hA5;
            if (k != 0) cycle();
            o = get_obs(1);
            chk($sformatf("ignore_a%0d", k), 32'(o.a), 32'(cap_a[k]));
            chk($sformatf("ignore_b%0d", k), 32'(o.b), 32'(cap_b[k]));
            drv_v[1] = k[0];
            drv_a[1] = 8'($urandom);
            drv_b[1] = 8'($urandom);
        end
        drv_v[1] = 1'b0;
        cycle();
        o = get_obs(1);
        chk("ignore_done", 32'(o.done), 32'd1);
        repeat (3) cycle();

        // Randomized traffic on all instances against the stream model.
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 3; d++) begin
                drv_v[d] = ($urandom_range(0, 2) != 0);
                drv_a[d] = 8'($urandom);
                drv_b[d] = 8'($urandom);
            end
            if ($urandom_range(0, 99) == 0) do_async_reset();
            else cycle();
        end
        for (int d = 0; d < 3; d++) drv_v[d] = 1'b0;
        repeat (12) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
